// File: rtl/alu_share_arb_pkg.sv
// Shared types and widths for the two-requester ALU sharing block.
package alu_share_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int FLAG_W = 4;
  localparam int OP_W   = 4;
  localparam int IOR_W  = 2;
  // Wide enough for LAT-1 with LAT up to 15.
  localparam int CNT_W  = 4;

endpackage

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-way round-robin arbiter: a tie goes to whoever did not win last time.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  logic last_grant_q, last_grant_d;

  always_comb begin
    gnt_o        = 2'b00;
    last_grant_d = last_grant_q;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_grant_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
    if (accept_i && (gnt_o != 2'b00)) begin
      last_grant_d = gnt_o[1];
    end
  end

  // Reset value 1 makes requester 0 win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between two requesters with round-robin
// arbitration, a fixed settle time and per-requester flag registers.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req_valid,
  output logic              r0_req_ready,
  input  logic [DATA_W-1:0] r0_req_a,
  input  logic [DATA_W-1:0] r0_req_b,
  input  logic [OP_W-1:0]   r0_req_op,
  input  logic [IOR_W-1:0]  r0_req_ior,
  input  logic              r0_req_setf,
  output logic              r0_rsp_valid,
  input  logic              r0_rsp_ready,
  output logic [DATA_W-1:0] r0_rsp_result,
  output logic [FLAG_W-1:0] r0_flags,
  input  logic              r1_req_valid,
  output logic              r1_req_ready,
  input  logic [DATA_W-1:0] r1_req_a,
  input  logic [DATA_W-1:0] r1_req_b,
  input  logic [OP_W-1:0]   r1_req_op,
  input  logic [IOR_W-1:0]  r1_req_ior,
  input  logic              r1_req_setf,
  output logic              r1_rsp_valid,
  input  logic              r1_rsp_ready,
  output logic [DATA_W-1:0] r1_rsp_result,
  output logic [FLAG_W-1:0] r1_flags,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [IOR_W-1:0]  alu_ior,
  output logic              alu_set_flags,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic              busy,
  output logic              owner
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [IOR_W-1:0]    ior_q, ior_d;
  logic                setf_q, setf_d;
  logic                owner_q, owner_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [FLAG_W-1:0]   flags0_q, flags0_d, flags1_q, flags1_d;
  logic [1:0]          req, gnt;
  logic                accept;

  // Requests are only visible to the arbiter while idle and out of reset.
  assign req    = {r1_req_valid, r0_req_valid} & {2{(state_q == IDLE) && !rst}};
  assign accept = |gnt;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req),
    .accept_i (accept),
    .gnt_o    (gnt)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    ior_d    = ior_q;
    setf_d   = setf_q;
    owner_d  = owner_q;
    result_d = result_q;
    flags0_d = flags0_q;
    flags1_d = flags1_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = gnt[1] ? r1_req_a    : r0_req_a;
          b_d     = gnt[1] ? r1_req_b    : r0_req_b;
          op_d    = gnt[1] ? r1_req_op   : r0_req_op;
          ior_d   = gnt[1] ? r1_req_ior  : r0_req_ior;
          setf_d  = gnt[1] ? r1_req_setf : r0_req_setf;
          owner_d = gnt[1];
          cnt_d   = CNT_W'(LAT - 1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          result_d = alu_result;
          if (setf_q) begin
            if (owner_q) flags1_d = alu_flags;
            else         flags0_d = alu_flags;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (owner_q ? r1_rsp_ready : r0_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      ior_q    <= '0;
      setf_q   <= 1'b0;
      owner_q  <= 1'b0;
      result_q <= '0;
      flags0_q <= '0;
      flags1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      ior_q    <= ior_d;
      setf_q   <= setf_d;
      owner_q  <= owner_d;
      result_q <= result_d;
      flags0_q <= flags0_d;
      flags1_q <= flags1_d;
    end
  end

  // ALU operands come straight from the capture registers so they never glitch.
  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign alu_op        = op_q;
  assign alu_ior       = ior_q;
  assign alu_set_flags = (state_q == EXEC) && setf_q;

  assign r0_req_ready  = gnt[0];
  assign r1_req_ready  = gnt[1];
  assign r0_rsp_valid  = (state_q == RESP) && !owner_q;
  assign r1_rsp_valid  = (state_q == RESP) && owner_q;
  assign r0_rsp_result = result_q;
  assign r1_rsp_result = result_q;
  assign r0_flags      = flags0_q;
  assign r1_flags      = flags1_q;
  assign busy          = (state_q != IDLE);
  assign owner         = owner_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: two instances (LAT=1 and LAT=3), a bench ALU, a
// timestamp-based reference model checked every cycle, plus directed literals.
module tb_alu_share_arb;

  logic        clk;
  logic        rst          [2];
  logic        reqValid     [2][2];
  logic        reqReady     [2][2];
  logic [31:0] reqA         [2][2];
  logic [31:0] reqB         [2][2];
  logic [3:0]  reqOp        [2][2];
  logic [1:0]  reqIor       [2][2];
  logic        reqSetf      [2][2];
  logic        rspValid     [2][2];
  logic        rspReady     [2][2];
  logic [31:0] rspResult    [2][2];
  logic [3:0]  flags        [2][2];
  logic [31:0] aluA         [2];
  logic [31:0] aluB         [2];
  logic [3:0]  aluOp        [2];
  logic [1:0]  aluIor       [2];
  logic        aluSetFlags  [2];
  logic [31:0] aluResult    [2];
  logic [3:0]  aluFlags     [2];
  logic        busy         [2];
  logic        owner        [2];

  int nVec, nMis, cyc;

  bit          mBusy  [2];
  bit          mOwn   [2];
  bit          mLast  [2];
  bit          mSetf  [2];
  int          mAcc   [2];
  logic [31:0] mA     [2];
  logic [31:0] mB     [2];
  logic [31:0] mRes   [2];
  logic [3:0]  mOp    [2];
  logic [1:0]  mIor   [2];
  logic [3:0]  mFlags [2][2];

  // Bench ALU: 1010 add, 1011 sub, otherwise xor; flags are {N, C, Z, V}.
  function automatic logic [35:0] aluFn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic        v;
    case (op)
      4'b1010: begin
        s = {1'b0, a} + {1'b0, b};
        v = (a[31] == b[31]) && (s[31] != a[31]);
      end
      4'b1011: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        v = (a[31] != b[31]) && (s[31] != a[31]);
      end
      default: begin
        s = {1'b0, a ^ b};
        v = 1'b0;
      end
    endcase
    return {s[31:0], s[31], s[32], (s[31:0] == 32'd0), v};
  endfunction

  for (genvar k = 0; k < 2; k++) begin : gDut
    alu_share_arb #(.DATA_W(32), .LAT(k == 0 ? 1 : 3)) dut (
      .clk           (clk),
      .rst           (rst[k]),
      .r0_req_valid  (reqValid[k][0]),
      .r0_req_ready  (reqReady[k][0]),
      .r0_req_a      (reqA[k][0]),
      .r0_req_b      (reqB[k][0]),
      .r0_req_op     (reqOp[k][0]),
      .r0_req_ior    (reqIor[k][0]),
      .r0_req_setf   (reqSetf[k][0]),
      .r0_rsp_valid  (rspValid[k][0]),
      .r0_rsp_ready  (rspReady[k][0]),
      .r0_rsp_result (rspResult[k][0]),
      .r0_flags      (flags[k][0]),
      .r1_req_valid  (reqValid[k][1]),
      .r1_req_ready  (reqReady[k][1]),
      .r1_req_a      (reqA[k][1]),
      .r1_req_b      (reqB[k][1]),
      .r1_req_op     (reqOp[k][1]),
      .r1_req_ior    (reqIor[k][1]),
      .r1_req_setf   (reqSetf[k][1]),
      .r1_rsp_valid  (rspValid[k][1]),
      .r1_rsp_ready  (rspReady[k][1]),
      .r1_rsp_result (rspResult[k][1]),
      .r1_flags      (flags[k][1]),
      .alu_a         (aluA[k]),
      .alu_b         (aluB[k]),
      .alu_op        (aluOp[k]),
      .alu_ior       (aluIor[k]),
      .alu_set_flags (aluSetFlags[k]),
      .alu_result    (aluResult[k]),
      .alu_flags     (aluFlags[k]),
      .busy          (busy[k]),
      .owner         (owner[k])
    );
    assign {aluResult[k], aluFlags[k]} = aluFn(aluOp[k], aluA[k], aluB[k]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s inst%0d cycle %0d: got %h, expected %h", name, k, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input int k, input int n, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] op, input logic setf);
    reqA[k][n]     = a;
    reqB[k][n]     = b;
    reqOp[k][n]    = op;
    reqIor[k][n]   = 2'(n + 1);
    reqSetf[k][n]  = setf;
    reqValid[k][n] = 1'b1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // sel 0/1: reqReady of r0/r1; sel 2/3: rspValid of r0/r1. Returns at the negedge it is seen.
  task automatic waitSig(input int k, input int sel, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = (sel < 2) ? reqReady[k][sel] : rspValid[k][sel - 2];
    end
    checkOutput(name, k, 32'(seen), 32'd1);
  endtask

  task automatic modelReset(input int k);
    mBusy[k]     = 1'b0;
    mOwn[k]      = 1'b0;
    mLast[k]     = 1'b1;
    mSetf[k]     = 1'b0;
    mAcc[k]      = 0;
    mA[k]        = '0;
    mB[k]        = '0;
    mRes[k]      = '0;
    mOp[k]       = '0;
    mIor[k]      = '0;
    mFlags[k][0] = '0;
    mFlags[k][1] = '0;
  endtask

  // Reference model: an accepted op (time mAcc) responds from mAcc+LAT+1 until consumed.
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      int          lat;
      int          w;
      logic [1:0]  eg;
      bit          inResp, inExec;
      logic [35:0] rf;
      if (rst[k]) modelReset(k);
      lat = (k == 0) ? 1 : 3;
      eg  = 2'b00;
      if (!rst[k] && !mBusy[k]) begin
        if (reqValid[k][0] && reqValid[k][1]) eg = mLast[k] ? 2'b01 : 2'b10;
        else                                  eg = {reqValid[k][1], reqValid[k][0]};
      end
      inResp = mBusy[k] && (cyc > mAcc[k] + lat);
      inExec = mBusy[k] && !inResp;
      for (int n = 0; n < 2; n++) begin
        checkOutput($sformatf("m_r%0d_req_ready", n), k, 32'(reqReady[k][n]), 32'(eg[n]));
        checkOutput($sformatf("m_r%0d_rsp_valid", n), k, 32'(rspValid[k][n]), 32'(inResp && (mOwn[k] == n[0])));
        checkOutput($sformatf("m_r%0d_rsp_result", n), k, rspResult[k][n], mRes[k]);
        checkOutput($sformatf("m_r%0d_flags", n), k, 32'(flags[k][n]), 32'(mFlags[k][n]));
      end
      checkOutput("m_alu_a", k, aluA[k], mA[k]);
      checkOutput("m_alu_b", k, aluB[k], mB[k]);
      checkOutput("m_alu_op", k, 32'(aluOp[k]), 32'(mOp[k]));
      checkOutput("m_alu_ior", k, 32'(aluIor[k]), 32'(mIor[k]));
      checkOutput("m_alu_set_flags", k, 32'(aluSetFlags[k]), 32'(inExec && mSetf[k]));
      checkOutput("m_busy", k, 32'(busy[k]), 32'(mBusy[k]));
      checkOutput("m_owner", k, 32'(owner[k]), 32'(mOwn[k]));
      if (!rst[k]) begin
        if (eg != 2'b00) begin
          w        = eg[1] ? 1 : 0;
          mA[k]    = reqA[k][w];
          mB[k]    = reqB[k][w];
          mOp[k]   = reqOp[k][w];
          mIor[k]  = reqIor[k][w];
          mSetf[k] = reqSetf[k][w];
          mOwn[k]  = eg[1];
          mLast[k] = eg[1];
          mAcc[k]  = cyc;
          mBusy[k] = 1'b1;
        end else if (inExec && (cyc == mAcc[k] + lat)) begin
          rf      = aluFn(mOp[k], mA[k], mB[k]);
          mRes[k] = rf[35:4];
          if (mSetf[k]) mFlags[k][mOwn[k]] = rf[3:0];
        end else if (inResp && rspReady[k][mOwn[k]]) begin
          mBusy[k] = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int gq[$];
    int expPat[4];
    expPat = '{0, 1, 0, 1};
    nVec = 0;
    nMis = 0;
    cyc  = 0;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0;
      for (int n = 0; n < 2; n++) begin
        reqValid[k][n] = 1'b0;
        reqA[k][n]     = '0;
        reqB[k][n]     = '0;
        reqOp[k][n]    = '0;
        reqIor[k][n]   = '0;
        reqSetf[k][n]  = 1'b0;
        rspReady[k][n] = 1'b1;
      end
    end
    #1;
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 0, 32'(busy[0]), 32'd0);
    checkOutput("reset_result", 1, rspResult[1][0], 32'd0);
    checkOutput("reset_alu_a", 0, aluA[0], 32'd0);
    checkOutput("reset_owner", 1, 32'(owner[1]), 32'd0);
    tick;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    tick;

    // Single r0 add, LAT=1: ready at cycle 0, response at cycle 2.
    applyStimulus(0, 0, 32'd5, 32'd7, 4'b1010, 1'b1);
    @(negedge clk);
    checkOutput("t1_ready", 0, 32'(reqReady[0][0]), 32'd1);
    tick;
    reqValid[0][0] = 1'b0;
    @(negedge clk);
    checkOutput("t1_valid_early", 0, 32'(rspValid[0][0]), 32'd0);
    tick;
    @(negedge clk);
    checkOutput("t1_valid", 0, 32'(rspValid[0][0]), 32'd1);
    checkOutput("t1_result", 0, rspResult[0][0], 32'd12);
    checkOutput("t1_flags", 0, 32'(flags[0][0]), 32'd0);
    checkOutput("t1_r1_valid", 0, 32'(rspValid[0][1]), 32'd0);
    checkOutput("t1_r1_flags", 0, 32'(flags[0][1]), 32'd0);

    // Tie straight out of reset: r0 first, then r1 right after r0's response.
    tick;
    rst[0] = 1'b1;
    tick;
    rst[0] = 1'b0;
    tick;
    applyStimulus(0, 0, 32'd1, 32'd1, 4'b1010, 1'b0);
    applyStimulus(0, 1, 32'd8, 32'd3, 4'b1011, 1'b0);
    waitSig(0, 0, "t2_r0_ready");
    checkOutput("t2_r1_not_ready", 0, 32'(reqReady[0][1]), 32'd0);
    tick;
    reqValid[0][0] = 1'b0;
    waitSig(0, 2, "t2_r0_rsp");
    checkOutput("t2_r0_result", 0, rspResult[0][0], 32'd2);
    checkOutput("t2_owner0", 0, 32'(owner[0]), 32'd0);
    tick;
    @(negedge clk);
    checkOutput("t2_r1_ready", 0, 32'(reqReady[0][1]), 32'd1);
    tick;
    reqValid[0][1] = 1'b0;
    @(negedge clk);
    checkOutput("t2_owner1", 0, 32'(owner[0]), 32'd1);
    waitSig(0, 3, "t2_r1_rsp");
    checkOutput("t2_r1_result", 0, rspResult[0][1], 32'd5);
    tick;

    // Both hold valid: grants alternate.
    applyStimulus(0, 0, 32'hFFFF_FFFF, 32'd1, 4'b1010, 1'b1);
    applyStimulus(0, 1, 32'd100, 32'd30, 4'b1011, 1'b1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (reqReady[0][0]) gq.push_back(0);
      if (reqReady[0][1]) gq.push_back(1);
      tick;
    end
    reqValid[0][0] = 1'b0;
    reqValid[0][1] = 1'b0;
    checkOutput("t3_grant_count", 0, gq.size(), 32'd4);
    for (int i = 0; i < 4 && i < gq.size(); i++) begin
      checkOutput($sformatf("t3_grant%0d", i), 0, gq[i], expPat[i]);
    end

    // LAT=3 with response back-pressure.
    rspReady[1][0] = 1'b0;
    applyStimulus(1, 0, 32'd10, 32'd20, 4'b1010, 1'b0);
    waitSig(1, 0, "t4_r0_ready");
    tick;
    applyStimulus(1, 0, 32'd11, 32'd22, 4'b1010, 1'b0);
    applyStimulus(1, 1, 32'd40, 32'd2, 4'b1011, 1'b0);
    waitSig(1, 2, "t4_rsp");
    for (int i = 0; i < 10; i++) begin
      checkOutput("t4_hold_valid", 1, 32'(rspValid[1][0]), 32'd1);
      checkOutput("t4_hold_result", 1, rspResult[1][0], 32'd30);
      checkOutput("t4_hold_busy", 1, 32'(busy[1]), 32'd1);
      checkOutput("t4_hold_r0_ready", 1, 32'(reqReady[1][0]), 32'd0);
      checkOutput("t4_hold_r1_ready", 1, 32'(reqReady[1][1]), 32'd0);
      tick;
      @(negedge clk);
    end
    tick;
    rspReady[1][0] = 1'b1;
    @(negedge clk);
    checkOutput("t4_release_valid", 1, 32'(rspValid[1][0]), 32'd1);
    tick;
    @(negedge clk);
    checkOutput("t4_idle_busy", 1, 32'(busy[1]), 32'd0);
    checkOutput("t4_idle_r1_ready", 1, 32'(reqReady[1][1]), 32'd1);
    checkOutput("t4_idle_r0_ready", 1, 32'(reqReady[1][0]), 32'd0);
    tick;
    reqValid[1][0] = 1'b0;
    reqValid[1][1] = 1'b0;
    waitSig(1, 3, "t4_r1_rsp");
    checkOutput("t4_r1_result", 1, rspResult[1][1], 32'd38);
    tick;

    // Flag update on zero result, then hold with setf=0.
    applyStimulus(1, 1, 32'd7, 32'd7, 4'b1011, 1'b1);
    waitSig(1, 1, "t5a_ready");
    tick;
    reqValid[1][1] = 1'b0;
    waitSig(1, 3, "t5a_rsp");
    checkOutput("t5a_result", 1, rspResult[1][1], 32'd0);
    checkOutput("t5a_zflag", 1, 32'(flags[1][1][1]), 32'd1);
    checkOutput("t5a_flags", 1, 32'(flags[1][1]), 32'h6);
    checkOutput("t5a_r0_flags", 1, 32'(flags[1][0]), 32'd0);
    tick;
    applyStimulus(1, 1, 32'd2, 32'd3, 4'b1010, 1'b0);
    waitSig(1, 1, "t5b_ready");
    tick;
    reqValid[1][1] = 1'b0;
    waitSig(1, 3, "t5b_rsp");
    checkOutput("t5b_result", 1, rspResult[1][1], 32'd5);
    checkOutput("t5b_flags", 1, 32'(flags[1][1]), 32'h6);
    checkOutput("t5b_r0_flags", 1, 32'(flags[1][0]), 32'd0);
    tick;

    // Reset during the second EXEC cycle drops the op.
    applyStimulus(1, 0, 32'd9, 32'd9, 4'b1010, 1'b1);
    waitSig(1, 0, "t6_ready");
    tick;
    reqValid[1][0] = 1'b0;
    tick;
    rst[1] = 1'b1;
    @(negedge clk);
    checkOutput("t6_busy", 1, 32'(busy[1]), 32'd0);
    checkOutput("t6_r0_valid", 1, 32'(rspValid[1][0]), 32'd0);
    checkOutput("t6_r1_flags", 1, 32'(flags[1][1]), 32'd0);
    checkOutput("t6_result", 1, rspResult[1][0], 32'd0);
    tick;
    rst[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("t6_no_rsp", 1, 32'(rspValid[1][0] | rspValid[1][1]), 32'd0);
      tick;
    end
    applyStimulus(1, 0, 32'd3, 32'd4, 4'b1010, 1'b0);
    applyStimulus(1, 1, 32'd5, 32'd6, 4'b1010, 1'b0);
    @(negedge clk);
    checkOutput("t6_tie_r0", 1, 32'(reqReady[1][0]), 32'd1);
    checkOutput("t6_tie_r1", 1, 32'(reqReady[1][1]), 32'd0);
    tick;
    reqValid[1][0] = 1'b0;
    reqValid[1][1] = 1'b0;
    waitSig(1, 2, "t6_rsp");
    checkOutput("t6_result_after", 1, rspResult[1][0], 32'd7);
    repeat (3) tick;

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one combinational ALU datapath between two requesters, r0 (core execute) and r1 (auxiliary address/DMA engine).
- Arbitrates round-robin and captures the winner's operands.
- Drives the ALU for LAT cycles so the result can settle, then registers the result and returns it through a valid/ready response.
- Keeps a separate 4-bit NZCV-style flag register for each requester.

Parameters:
- DATA_W, 32, operand/result width
- LAT, 1, ALU settle cycles per operation (legal range 1..15)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rN_req_valid  in  1  requester N (N=0,1) has an operation
- rN_req_ready  out  1  operation accepted this cycle
- rN_req_a  in  DATA_W  operand a
- rN_req_b  in  DATA_W  operand b
- rN_req_op  in  4  ALU opcode, passed through unmodified
- rN_req_ior  in  2  immediate/register select, passed through
- rN_req_setf  in  1  update this requester's flags
- rN_rsp_valid  out  1  result available
- rN_rsp_ready  in  1  requester consumes result
- rN_rsp_result  out  DATA_W  registered result
- rN_flags  out  4  requester N flag register
- alu_a  out  DATA_W  shared ALU operand a
- alu_b  out  DATA_W  shared ALU operand b
- alu_op  out  4  shared ALU opcode
- alu_ior  out  2  shared ALU immediate/register select
- alu_set_flags  out  1  shared ALU flag-update enable
- alu_result  in  DATA_W  ALU result
- alu_flags  in  4  ALU flags
- busy  out  1  state != IDLE
- owner  out  1  requester currently being served

Behaviour:
- Reset (async, rst=1) clears:
  - state=IDLE, all ready/valid outputs = 0, rsp_result = 0, flags = 0.
  - alu_* outputs = 0; last_grant = 1, so r0 wins first; owner = 0.
  - The settle counter.
- Reset mid-operation drops the in-flight op; no response is issued.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - Grant rule: if exactly one rN_req_valid is high, grant it. If both are high, grant the requester that is not last_grant.
  - rN_req_ready = 1 combinationally, only for the granted N and only in IDLE.
  - On a handshake: capture a/b/op/ior/setf into operand registers, set owner = N, set last_grant = N, load counter = LAT-1, go to EXEC.
  - If no request is valid, stay in IDLE.
- EXEC:
  - alu_a/b/op/ior are driven from the captured registers.
  - alu_set_flags = captured setf.
  - Counter decrements each cycle.
  - When counter == 0: rsp_result <= alu_result; if setf, flags[owner] <= alu_flags; go to RESP.
- RESP:
  - r[owner]_rsp_valid = 1 (registered). Result and valid are held stable until r[owner]_rsp_ready = 1.
  - On the handshake cycle, go to IDLE.
  - No new request is accepted in RESP; at most one op is outstanding.
- Timing:
  - Accept at cycle T → rsp_valid first high at T+LAT+1.
  - Minimum issue interval is LAT+2 cycles.
- The non-owner's rsp_valid is always 0.
- Flags:
  - flags[N] are updated only in EXEC when setf=1; otherwise they hold.
  - The two flag registers are fully independent.
- Outside EXEC:
  - alu_set_flags = 0.
  - alu_a/b/op/ior hold their last captured values (no glitching toward the ALU).
- Requester rules:
  - A requester deasserting req_valid before acceptance is legal; nothing is captured.
  - req_* fields are sampled only on the handshake cycle.
- Opcode and width: opcode semantics belong to the ALU; this block never decodes op. All data paths are DATA_W wide with no truncation.

Decomposition:
- Shared package holds the FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2), FLAG_W=4, OP_W=4, IOR_W=2.
- One natural sub-module, rr_arb2: a 2-way round-robin grant with a last_grant register.
  - Inputs: req[1:0], accept strobe.
  - Output: gnt[1:0], one-hot or zero.

Test Plan:
- (Bench binds the team ALU to the alu_* ports.)
- LAT=1; r0 valid with a=5, b=7, op=4'b1010 (add), setf=1 at cycle 0 → r0_req_ready=1 at cycle 0; r0_rsp_valid=1 at cycle 2 with result 12; r0_flags=4'b0000; r1 outputs untouched.
- Both valid from reset: r0 a=1, b=1, op=1010; r1 a=8, b=3, op=1011 (sub) → r0 is served first (result 2); r1 is accepted in the cycle after r0's rsp handshake (result 5); owner toggles 0→1.
- r0 holds valid continuously for 3 ops while r1 holds valid → grants alternate r0, r1, r0, r1; neither requester is starved.
- LAT=3; rsp_ready held low for 10 cycles → rsp_valid and result are held stable, busy=1, no req_ready to either side; release → IDLE next cycle.
- r1 op with setf=1 producing result 0 → r1_flags[1]=1; a following r1 op with setf=0 and a nonzero result leaves r1_flags unchanged; r0_flags unaffected throughout.
- Assert rst in the 2nd EXEC cycle (LAT=3) → immediately state=IDLE, all valids=0, flags=0; no response for the dropped op; the next request is served normally, with r0 winning a tie.
